// File: rtl/im_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory load controller:
// FSM state encoding and the MIPS nop used to clear the memory.
package im_load_ctrl_pkg;

    // Controller states; encodings are fixed so that debug tooling can decode dbg_state.
    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_LOAD  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // MIPS "sll $0,$0,0" encodes as all zeros and executes as a nop.
    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/im_load_ctrl_wptr.sv
// Write pointer shared by the clear sweep and the program load.
// Clears to zero, increments on request, and sticks at the top address
// instead of rolling over; at_top_o flags the last word of the memory.
module im_load_ctrl_wptr
    import im_load_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              at_top_o
);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    assign ptr_o    = ptr_q;
    assign at_top_o = &ptr_q;

    // Next pointer: clear wins, increment saturates at the top address.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i && !at_top_o) begin
            ptr_d = ptr_q + ADDR_W'(1);
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/im_load_ctrl.sv
// Instruction-memory port owner: clears the memory after reset, then
// multiplexes the single port between CPU fetch and a streaming loader.
//
// Loader handshake: a word transfers on a cycle where ld_valid and ld_ready
// are both 1. ld_ready is 1 only in LOAD (and never during reset); ld_data
// and ld_last are sampled only on transfer cycles, and the word is written to
// memory in that same cycle.
//
// Optional feature: define IM_CHECKSUM_EN to add ld_csum, a running XOR of
// every accepted loader word.
module im_load_ctrl
    import im_load_ctrl_pkg::*;
#(
    parameter int                 ADDR_W     = 8,
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  CLEAR_WORD = DATA_W'(MIPS_NOP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_stall,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count,
    output logic [1:0]        dbg_state
`ifdef IM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] ld_csum
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] wptr;
    logic              at_top;
    logic              wp_clr;
    logic              wp_inc;
    logic              start_load;
    logic              accept;
    logic              set_err;
    logic [ADDR_W:0]   word_count_q;
    logic              load_err_q;

    im_load_ctrl_wptr #(
        .ADDR_W (ADDR_W)
    ) u_wptr (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (wp_clr),
        .inc_i    (wp_inc),
        .ptr_o    (wptr),
        .at_top_o (at_top)
    );

    assign word_count = word_count_q;
    assign load_err   = load_err_q;
    assign dbg_state  = state_q;

    // Next state and port mux; reset overrides everything so the port is quiet while held.
    always_comb begin
        state_d    = state_q;
        wp_clr     = 1'b0;
        wp_inc     = 1'b0;
        start_load = 1'b0;
        accept     = 1'b0;
        set_err    = 1'b0;
        mem_addr   = fetch_addr;
        mem_we     = 1'b0;
        mem_wdata  = CLEAR_WORD;
        cpu_stall  = 1'b1;
        ld_ready   = 1'b0;
        load_done  = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = wptr;
                wp_inc   = 1'b1;
                if (at_top) begin
                    state_d = S_DONE;
                end
            end
            S_RUN: begin
                cpu_stall = 1'b0;
                if (ld_start) begin
                    state_d    = S_LOAD;
                    wp_clr     = 1'b1;
                    start_load = 1'b1;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                mem_addr = wptr;
                if (ld_valid) begin
                    accept    = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = ld_data;
                    wp_inc    = 1'b1;
                    if (ld_last) begin
                        state_d = S_DONE;
                    end else if (at_top) begin
                        set_err = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                load_done = 1'b1;
                state_d   = S_RUN;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
        if (reset) begin
            state_d   = S_CLEAR;
            wp_clr    = 1'b1;
            accept    = 1'b0;
            mem_we    = 1'b0;
            ld_ready  = 1'b0;
            load_done = 1'b0;
            cpu_stall = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Load status: word count saturates at DEPTH, overflow error is sticky until the next load.
    always_ff @(posedge clk) begin
        if (reset || start_load) begin
            word_count_q <= '0;
            load_err_q   <= 1'b0;
        end else begin
            if (accept && (word_count_q != (ADDR_W + 1)'(DEPTH))) begin
                word_count_q <= word_count_q + (ADDR_W + 1)'(1);
            end
            if (set_err) begin
                load_err_q <= 1'b1;
            end
        end
    end

`ifdef IM_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    assign ld_csum = csum_q;

    // Running XOR of accepted loader words, restarted with each load.
    always_ff @(posedge clk) begin
        if (reset || start_load) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q ^ ld_data;
        end
    end
`endif

endmodule
